// File: rtl/fifo_status_ctrl.sv
// fifo_status_ctrl: FIFO full/empty/level, almost flags with hysteresis, sticky errors; FIFO_STATUS_ERRCNT_EN adds event counters
module fifo_status_ctrl #(
    parameter int ADDR_W = 9,
    parameter int HYST   = 2
`ifdef FIFO_STATUS_ERRCNT_EN
    ,
    parameter int CNT_W  = 8
`endif
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr,
    input  logic              rd,
    input  logic              fifo_we,
    input  logic              fifo_rd,
    input  logic [ADDR_W:0]   wptr,
    input  logic [ADDR_W:0]   rptr,
    input  logic [ADDR_W:0]   af_thresh,
    input  logic [ADDR_W:0]   ae_thresh,
    input  logic              clr_err,
    output logic              fifo_full,
    output logic              fifo_empty,
    output logic [ADDR_W:0]   fifo_level,
    output logic              fifo_almost_full,
    output logic              fifo_almost_empty,
    output logic              fifo_overflow,
    output logic              fifo_underflow,
    output logic              ptr_err
`ifdef FIFO_STATUS_ERRCNT_EN
    ,
    output logic [CNT_W-1:0]  ovf_cnt,
    output logic [CNT_W-1:0]  udf_cnt
`endif
);
    localparam int PW = ADDR_W + 1;
    localparam logic [PW:0] DEPTH_X = (PW + 1)'(1) << ADDR_W;
    localparam logic [PW:0] HYST_X  = (PW + 1)'(HYST);

    logic [PW-1:0] diff;
    logic [PW:0]   diff_x, af_x, ae_x, af_lo, ae_sum, ae_hi;
    logic          ovf_evt, udf_evt, perr_evt;
    logic [PW-1:0] level_d, level_q;
    logic          af_d, af_q, ae_d, ae_q;
    logic          ovf_d, ovf_q, udf_d, udf_q, perr_d, perr_q;

    assign diff       = wptr - rptr;
    assign diff_x     = {1'b0, diff};
    assign fifo_full  = diff_x == DEPTH_X;
    assign fifo_empty = diff == '0;

    // Next-state for level, hysteretic almost flags and sticky error flags
    always_comb begin
        af_x     = {1'b0, af_thresh};
        ae_x     = {1'b0, ae_thresh};
        af_lo    = af_x > HYST_X ? af_x - HYST_X : '0;
        ae_sum   = ae_x + HYST_X;
        ae_hi    = ae_sum > DEPTH_X ? DEPTH_X : ae_sum;
        ovf_evt  = wr & fifo_full & ~fifo_rd;
        udf_evt  = rd & fifo_empty & ~fifo_we;
        perr_evt = diff_x > DEPTH_X;
        level_d  = perr_evt ? DEPTH_X[PW-1:0] : diff;
        af_d     = diff_x >= af_x ? 1'b1 : diff_x < af_lo ? 1'b0 : af_q;
        ae_d     = diff_x <= ae_x ? 1'b1 : diff_x > ae_hi ? 1'b0 : ae_q;
        ovf_d    = ovf_evt | (ovf_q & ~clr_err);
        udf_d    = udf_evt | (udf_q & ~clr_err);
        perr_d   = perr_evt | (perr_q & ~clr_err);
    end

    // Status registers; reset leaves the FIFO looking empty with no errors
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            level_q <= '0;
            af_q    <= 1'b0;
            ae_q    <= 1'b1;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
            perr_q  <= 1'b0;
        end else begin
            level_q <= level_d;
            af_q    <= af_d;
            ae_q    <= ae_d;
            ovf_q   <= ovf_d;
            udf_q   <= udf_d;
            perr_q  <= perr_d;
        end
    end

    assign fifo_level        = level_q;
    assign fifo_almost_full  = af_q;
    assign fifo_almost_empty = ae_q;
    assign fifo_overflow     = ovf_q;
    assign fifo_underflow    = udf_q;
    assign ptr_err           = perr_q;

`ifdef FIFO_STATUS_ERRCNT_EN
    logic [CNT_W-1:0] ovf_cnt_d, ovf_cnt_q, udf_cnt_d, udf_cnt_q;

    // Saturating event counters; a clear coinciding with an event restarts at one
    always_comb begin
        ovf_cnt_d = clr_err ? CNT_W'(ovf_evt) :
                    (ovf_evt && ovf_cnt_q != '1) ? ovf_cnt_q + 1'b1 : ovf_cnt_q;
        udf_cnt_d = clr_err ? CNT_W'(udf_evt) :
                    (udf_evt && udf_cnt_q != '1) ? udf_cnt_q + 1'b1 : udf_cnt_q;
    end

    // Counter registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ovf_cnt_q <= '0;
            udf_cnt_q <= '0;
        end else begin
            ovf_cnt_q <= ovf_cnt_d;
            udf_cnt_q <= udf_cnt_d;
        end
    end

    assign ovf_cnt = ovf_cnt_q;
    assign udf_cnt = udf_cnt_q;
`endif
endmodule

// File: tb/tb_fifo_status_ctrl.sv
// tb_fifo_status_ctrl: directed checks of fifo_status_ctrl (ADDR_W=9, HYST=2; CNT_W=2 when FIFO_STATUS_ERRCNT_EN)
module tb_fifo_status_ctrl;
    logic       clk = 1'b0;
    logic       rst_n, wr, rd, fifo_we, fifo_rd, clr_err;
    logic [9:0] wptr, rptr, af_thresh, ae_thresh;
    logic       fifo_full, fifo_empty, fifo_almost_full, fifo_almost_empty;
    logic       fifo_overflow, fifo_underflow, ptr_err;
    logic [9:0] fifo_level;
    int         total = 0;
    int         bad = 0;
`ifdef FIFO_STATUS_ERRCNT_EN
    logic [1:0] ovf_cnt, udf_cnt;
`endif

    fifo_status_ctrl #(
        .ADDR_W(9),
        .HYST(2)
`ifdef FIFO_STATUS_ERRCNT_EN
        ,
        .CNT_W(2)
`endif
    ) dut (
        .clk(clk), .rst_n(rst_n), .wr(wr), .rd(rd), .fifo_we(fifo_we), .fifo_rd(fifo_rd),
        .wptr(wptr), .rptr(rptr), .af_thresh(af_thresh), .ae_thresh(ae_thresh), .clr_err(clr_err),
        .fifo_full(fifo_full), .fifo_empty(fifo_empty), .fifo_level(fifo_level),
        .fifo_almost_full(fifo_almost_full), .fifo_almost_empty(fifo_almost_empty),
        .fifo_overflow(fifo_overflow), .fifo_underflow(fifo_underflow), .ptr_err(ptr_err)
`ifdef FIFO_STATUS_ERRCNT_EN
        ,
        .ovf_cnt(ovf_cnt), .udf_cnt(udf_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic ptrs(input logic [9:0] w, input logic [9:0] r);
        wptr = w;
        rptr = r;
        step();
    endtask

    initial begin
        rst_n = 0; wr = 0; rd = 0; fifo_we = 0; fifo_rd = 0; clr_err = 0;
        wptr = 0; rptr = 0; af_thresh = 10'd500; ae_thresh = 10'd4;
        step(2);
        chk("rst_level", fifo_level, 0);
        chk("rst_af", fifo_almost_full, 0);
        chk("rst_ae", fifo_almost_empty, 1);
        chk("rst_ovf", fifo_overflow, 0);
        chk("rst_udf", fifo_underflow, 0);
        chk("rst_perr", ptr_err, 0);
        chk("rst_empty", fifo_empty, 1);
        chk("rst_full", fifo_full, 0);
`ifdef FIFO_STATUS_ERRCNT_EN
        chk("rst_ovfcnt", ovf_cnt, 0);
        chk("rst_udfcnt", udf_cnt, 0);
`endif
        rst_n = 1;
        // full at 512 entries
        wptr = 10'h200; rptr = 0; #1;
        chk("full_comb", fifo_full, 1);
        chk("full_empty", fifo_empty, 0);
        step();
        chk("full_level", fifo_level, 512);
        chk("full_af", fifo_almost_full, 1);
        chk("full_ae", fifo_almost_empty, 0);
        wr = 1; fifo_rd = 0; step(); wr = 0;
        chk("ovf_set", fifo_overflow, 1);
`ifdef FIFO_STATUS_ERRCNT_EN
        chk("ovf_cnt1", ovf_cnt, 1);
`endif
        step();
        chk("ovf_sticky", fifo_overflow, 1);
        clr_err = 1; step(); clr_err = 0;
        chk("ovf_clr", fifo_overflow, 0);
`ifdef FIFO_STATUS_ERRCNT_EN
        chk("ovf_cnt_clr", ovf_cnt, 0);
`endif
        wr = 1; fifo_rd = 1; step(); wr = 0; fifo_rd = 0;
        chk("ovf_rd_masks", fifo_overflow, 0);
        // almost-full hysteresis, af_thresh=500
        ptrs(10'd100, 0);
        chk("af_low", fifo_almost_full, 0);
        chk("ae_low_clr", fifo_almost_empty, 0);
        ptrs(10'd499, 0);
        chk("af_499", fifo_almost_full, 0);
        ptrs(10'd500, 0);
        chk("af_500", fifo_almost_full, 1);
        chk("lvl_500", fifo_level, 500);
        ptrs(10'd499, 0);
        chk("af_hold499", fifo_almost_full, 1);
        ptrs(10'd498, 0);
        chk("af_hold498", fifo_almost_full, 1);
        ptrs(10'd497, 0);
        chk("af_clr497", fifo_almost_full, 0);
        // almost-empty hysteresis, ae_thresh=4
        ptrs(10'd6, 0);
        chk("ae_hold6_off", fifo_almost_empty, 0);
        ptrs(10'd4, 0);
        chk("ae_set4", fifo_almost_empty, 1);
        ptrs(10'd6, 0);
        chk("ae_hold6_on", fifo_almost_empty, 1);
        ptrs(10'd7, 0);
        chk("ae_clr7", fifo_almost_empty, 0);
        // af_thresh <= HYST never clears
        af_thresh = 10'd2;
        ptrs(10'd5, 0);
        chk("af_small_set", fifo_almost_full, 1);
        ptrs(0, 0);
        chk("af_small_hold", fifo_almost_full, 1);
        af_thresh = 10'd500;
        step();
        chk("af_thr_change", fifo_almost_full, 0);
        // underflow
        rd = 1; fifo_we = 0; step(3);
        chk("udf_set", fifo_underflow, 1);
`ifdef FIFO_STATUS_ERRCNT_EN
        chk("udf_cnt3", udf_cnt, 3);
`endif
        clr_err = 1; step();
        chk("udf_clr_evt", fifo_underflow, 1);
`ifdef FIFO_STATUS_ERRCNT_EN
        chk("udf_cnt_clr_evt", udf_cnt, 1);
`endif
        rd = 0; step(); clr_err = 0;
        chk("udf_clr", fifo_underflow, 0);
        rd = 1; fifo_we = 1; step(); rd = 0; fifo_we = 0;
        chk("udf_we_masks", fifo_underflow, 0);
        // wrap and pointer error
        wptr = 10'h001; rptr = 10'h3FF; #1;
        chk("wrap_empty", fifo_empty, 0);
        step();
        chk("wrap_level", fifo_level, 2);
        chk("wrap_perr", ptr_err, 0);
        wptr = 10'h300; rptr = 0; #1;
        chk("perr_full", fifo_full, 0);
        step();
        chk("perr_set", ptr_err, 1);
        chk("perr_level", fifo_level, 512);
        ptrs(0, 0);
        chk("perr_sticky", ptr_err, 1);
        chk("perr_lvl0", fifo_level, 0);
        clr_err = 1; step(); clr_err = 0;
        chk("perr_clr", ptr_err, 0);
        // overflow counter saturation, then reset overriding events
        wptr = 10'h200; rptr = 0; wr = 1; fifo_rd = 0; step(5);
        chk("ovf_again", fifo_overflow, 1);
`ifdef FIFO_STATUS_ERRCNT_EN
        chk("ovf_cnt_sat", ovf_cnt, 3);
        wr = 0; clr_err = 1; step(); clr_err = 0;
        chk("ovf_cnt_zero", ovf_cnt, 0);
        wr = 1; step();
`endif
        rst_n = 0; step(); wr = 0;
        chk("mid_rst_ovf", fifo_overflow, 0);
        chk("mid_rst_level", fifo_level, 0);
        chk("mid_rst_ae", fifo_almost_empty, 1);
        chk("mid_rst_af", fifo_almost_full, 0);
`ifdef FIFO_STATUS_ERRCNT_EN
        chk("mid_rst_cnt", ovf_cnt, 0);
`endif
        rst_n = 1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
